arq_tx: RTL and testbench
=========================

# arq_tx

Transmit-side ARQ (automatic repeat request) engine. It sits between a word source and the ECC FIFO receiver and drives that receiver's `wr_en`/`data_in` link. It takes one word at a time, sends it with an even-parity bit, then waits for the receiver's `ack`/`nack`. It retransmits on `nack` or timeout until a retry limit is reached.

## Interface
- `DATA_WIDTH`, default 8: payload width.
- `MAX_RETRY`, default 3: maximum retransmissions per word (1..15).
- `TIMEOUT`, default 15: WAIT cycles before an implicit nack (1..256).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `src_valid`  in  1: source offers a word.
- `src_data`  in  DATA_WIDTH: word offered.
- `src_ready`  out  1: engine idle and able to accept.
- `tx_valid`  out  1: one-cycle strobe to the receiver's `wr_en`.
- `tx_data`  out  DATA_WIDTH: word being sent (to the receiver's `data_in`).
- `tx_parity`  out  1: even parity of `tx_data` (XOR of all bits).
- `ack`  in  1: receiver accepted the word.
- `nack`  in  1: receiver rejected the word.
- `busy`  out  1: a word is in flight.
- `done`  out  1: one-cycle pulse, word acknowledged.
- `fail`  out  1: one-cycle pulse, retry limit exhausted and word dropped.
- `retry_cnt`  out  4: retransmissions made for the current or last word.

## Operation
- States: IDLE, SEND, WAIT.
- `src_ready` = (state==IDLE); `busy` = !IDLE; `tx_valid` = (state==SEND). All three are decoded from the state register.
- **IDLE:**
  - If `src_valid`: latch `src_data` into the buffer, clear `retry_cnt`, go to SEND.
  - `ack`/`nack` are ignored.
- **SEND:**
  - `tx_valid`=1 for exactly one cycle.
  - Clear the timer, go to WAIT.
  - `ack`/`nack` are ignored.
- **WAIT:** the timer increments every cycle, starting at 0 in the first WAIT cycle.
  - `ack`=1 goes to IDLE with `done`=1 next cycle. `ack` wins over a simultaneous `nack` or timeout.
  - Otherwise, `nack`=1 or timer==TIMEOUT-1 counts as a retry event:
    - If `retry_cnt`<MAX_RETRY: increment `retry_cnt`, go to SEND.
    - Else: go to IDLE with `fail`=1 next cycle.
- `tx_data` always reflects the buffer. It is stable for the whole transaction and holds its last value after `done`/`fail`. `tx_parity` is computed combinationally from the buffer.
- `retry_cnt` holds after `done`/`fail` until the next accept. It saturates at MAX_RETRY and never wraps.
- `src_valid` while busy is ignored. The source must hold its word until `src_ready`.
- Reset values: state IDLE (`src_ready`=1), `tx_valid`=0, `busy`=0, `tx_data`=0, `tx_parity`=0, `done`=0, `fail`=0, `retry_cnt`=0, timer=0.
- Reset during SEND/WAIT aborts the word silently: no `done`, no `fail`.

## Timing
- Accept at edge N (`src_valid`&&`src_ready`) gives:
  - `tx_valid` high in cycle N+1;
  - WAIT from cycle N+2.
- `ack` sampled high in WAIT cycle M gives `done` high and `src_ready` high in cycle M+1. A new word can be accepted at the end of M+1.
- Minimum transaction: 3 cycles (SEND, one WAIT cycle with `ack`, then the IDLE/`done` cycle).
- Retransmit after `nack` in cycle M: `tx_valid` in cycle M+1.
- Pure timeout: `tx_valid` strobes spaced TIMEOUT+1 cycles apart.
- Worst case to `fail`: (MAX_RETRY+1)×(TIMEOUT+1) cycles after the accept edge.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs. After release: `src_ready`=1, `tx_valid`=0, `tx_data`=0x00, `busy`/`done`/`fail`=0, `retry_cnt`=0.
- **Clean send:** offer 0xA5, `ack` 3 cycles after `tx_valid`. Expect:
  - exactly one `tx_valid` with `tx_data`=0xA5, `tx_parity`=0;
  - `done` pulse one cycle after `ack`;
  - `retry_cnt`=0.
- **Nack recovery:** offer 0x07, `nack` on the first two sends, `ack` on the third. Expect:
  - three `tx_valid` strobes, all 0x07 with `tx_parity`=1;
  - `retry_cnt`=2, `done`=1, no `fail`.
- **Retry exhaustion:** defaults, `nack` held high. Expect:
  - 4 `tx_valid` strobes;
  - `fail` pulse after the 4th `nack`;
  - `retry_cnt`=3, `src_ready`=1 in the `fail` cycle.
- **Timeout:** no `ack`/`nack`, TIMEOUT=15. Expect:
  - `tx_valid` strobes 16 cycles apart;
  - `fail` 64 cycles after the accept edge.
- **Corner cases:**
  - `ack`&&`nack` together in WAIT: `done`, not a retransmit.
  - `src_valid`=1 with 0xFF while busy: ignored, `tx_data` unchanged.
  - `rst` asserted mid-WAIT: all reset values next cycle, no `done`/`fail`.

Source files
------------

// File: rtl/arq_tx.sv
// Transmit-side ARQ engine: sends one buffered word with even parity, then
// retransmits on nack or timeout until the retry budget is spent.
module arq_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_parity,
    input  logic                  ack,
    input  logic                  nack,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [3:0]            retry_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Nine bits covers the largest timer value (TIMEOUT-1 = 255).
    localparam int              TW        = 9;
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [3:0]            retry_q, retry_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        retry_d = retry_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_valid) begin
                    buf_d   = src_data;
                    retry_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // ack has priority over both nack and an expiring timer.
                if (ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (nack || (timer_q == TMO_LAST)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                        fail_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            retry_q <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Parity as an explicit XOR chain over the buffered word.
    logic [DATA_WIDTH:0] par_chain;
    assign par_chain[0] = 1'b0;
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ buf_q[gi];
    end

    assign src_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx_valid  = (state_q == ST_SEND);
    assign tx_data   = buf_q;
    assign tx_parity = par_chain[DATA_WIDTH];
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_arq_tx.sv
// Randomized bench for arq_tx: each word gets a per-attempt response plan and
// a transaction-level prediction of its outcome, strobe count and duration.
module tb_arq_tx;

    localparam int DW = 8;
    localparam int MR = 3;
    localparam int T  = 15;

    localparam int P_ACK  = 0;
    localparam int P_NACK = 1;
    localparam int P_BOTH = 2;
    localparam int P_NONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_parity;
    logic          ack;
    logic          nack;
    logic          busy;
    logic          done;
    logic          fail;
    logic [3:0]    retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int plan_type [MR+1];
    int plan_del  [MR+1];

    arq_tx #(.DATA_WIDTH(DW), .MAX_RETRY(MR), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_parity(tx_parity),
        .ack(ack), .nack(nack),
        .busy(busy), .done(done), .fail(fail), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_plan(input int idx, input int ty, input int dl);
        plan_type[idx] = ty;
        plan_del[idx]  = (ty == P_NONE) ? T - 1 : dl;
    endtask

    task automatic random_plan();
        for (int i = 0; i <= MR; i++)
            set_plan(i, $urandom_range(0, 3), $urandom_range(0, T - 1));
    endtask

    // Current cycle must be IDLE. Returns edges from accept to the result cycle.
    task automatic run_txn(input logic [DW-1:0] w, input bit hold_nack,
                           input bit busy_poke, output int edges);
        bit exp_done;
        int exp_retry, exp_sends, exp_edges;
        int n_tx, att, wt;
        bit fin;

        // Outcome predicted from the plan alone.
        exp_done = 1'b0; exp_retry = MR; exp_sends = 0; exp_edges = 0;
        for (int i = 0; i <= MR; i++) begin
            exp_sends = i + 1;
            exp_edges += plan_del[i] + 2;
            if (plan_type[i] == P_ACK || plan_type[i] == P_BOTH) begin
                exp_done  = 1'b1;
                exp_retry = i;
                break;
            end
        end

        src_valid = 1'b1;
        src_data  = w;
        ack       = 1'($urandom);
        nack      = hold_nack ? 1'b1 : 1'($urandom);
        tick();
        edges = 0; n_tx = 0; att = -1; wt = 0; fin = 1'b0;
        while (!fin && edges < 400) begin
            if (src_ready) begin
                fin = 1'b1;
            end else begin
                check_val("busy", busy, 1);
                check_val("tx_data_stable", tx_data, w);
                check_val("tx_parity", tx_parity, ^w);
                check_val("no_early_done", done, 0);
                check_val("no_early_fail", fail, 0);
                if (tx_valid) begin
                    n_tx++;
                    att++;
                    wt   = 0;
                    ack  = 1'($urandom);
                    nack = hold_nack ? 1'b1 : 1'($urandom);
                end else begin
                    ack  = 1'b0;
                    nack = hold_nack;
                    if (att >= 0 && att <= MR && wt == plan_del[att]) begin
                        case (plan_type[att])
                            P_ACK:   ack = 1'b1;
                            P_NACK:  nack = 1'b1;
                            P_BOTH:  begin ack = 1'b1; nack = 1'b1; end
                            default: ;
                        endcase
                    end
                    wt++;
                end
                check_val("retry_in_flight", retry_cnt, n_tx - 1);
                src_valid = busy_poke ? 1'b1 : 1'($urandom_range(0, 3) == 0);
                src_data  = busy_poke ? 8'hFF : 8'($urandom);
                tick();
                edges++;
            end
        end
        check_val("finished", fin, 1);
        check_val("done", done, exp_done);
        check_val("fail", fail, !exp_done);
        check_val("retry_cnt", retry_cnt, exp_retry);
        check_val("sends", n_tx, exp_sends);
        check_val("edges", edges, exp_edges);
        check_val("tx_data_hold", tx_data, w);
        $display("txn %0d data=%02h sends=%0d retry=%0d edges=%0d %s",
                 n_txn, w, n_tx, retry_cnt, edges, exp_done ? "acked" : "dropped");
        n_txn++;

        // Idle gap: pulses must be single-cycle, status must hold.
        ack = 1'b0; nack = 1'b0; src_valid = 1'b0;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
            ack  = 1'($urandom);
            nack = 1'($urandom);
            tick();
            check_val("idle_ready", src_ready, 1);
            check_val("idle_done", done, 0);
            check_val("idle_fail", fail, 0);
            check_val("idle_tx_valid", tx_valid, 0);
            check_val("idle_retry_hold", retry_cnt, exp_retry);
            check_val("idle_data_hold", tx_data, w);
        end
        ack = 1'b0; nack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_src_ready"}, src_ready, 1);
        check_val({tag, "_tx_valid"}, tx_valid, 0);
        check_val({tag, "_tx_data"}, tx_data, 0);
        check_val({tag, "_tx_parity"}, tx_parity, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_fail"}, fail, 0);
        check_val({tag, "_retry"}, retry_cnt, 0);
    endtask

    initial begin
        int e;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'($urandom);
            src_data  = 8'($urandom);
            ack       = 1'($urandom);
            nack      = 1'($urandom);
            tick();
        end
        rst = 1'b0; src_valid = 1'b0; ack = 1'b0; nack = 1'b0;
        check_reset_values("reset");

        // Clean send: ack in the third WAIT cycle.
        set_plan(0, P_ACK, 2);
        run_txn(8'hA5, 1'b0, 1'b0, e);

        // Two nacks then ack.
        set_plan(0, P_NACK, 0);
        set_plan(1, P_NACK, 0);
        set_plan(2, P_ACK, 0);
        run_txn(8'h07, 1'b0, 1'b0, e);

        // nack held high: exhaustion.
        for (int i = 0; i <= MR; i++) set_plan(i, P_NACK, 0);
        run_txn(8'h5A, 1'b1, 1'b0, e);

        // Pure timeout.
        for (int i = 0; i <= MR; i++) set_plan(i, P_NONE, 0);
        run_txn(8'h3C, 1'b0, 1'b0, e);
        check_val("timeout_to_fail", e, (MR + 1) * (T + 1));

        // ack and nack together, plus ack on the last timer cycle.
        set_plan(0, P_BOTH, 0);
        run_txn(8'h81, 1'b0, 1'b0, e);
        set_plan(0, P_NACK, 4);
        set_plan(1, P_ACK, T - 1);
        run_txn(8'h42, 1'b0, 1'b0, e);

        // 0xFF offered on every busy cycle must not disturb the word.
        set_plan(0, P_NACK, 1);
        set_plan(1, P_ACK, 3);
        run_txn(8'h12, 1'b0, 1'b1, e);

        // Reset mid-WAIT after one retransmission.
        src_valid = 1'b1; src_data = 8'hC3;
        tick();
        src_valid = 1'b0;
        tick();
        nack = 1'b1;
        tick();
        nack = 1'b0;
        tick();
        tick();
        check_val("pre_reset_retry", retry_cnt, 1);
        rst = 1'b1; ack = 1'b1;
        tick();
        check_reset_values("mid_wait_reset");
        rst = 1'b0; ack = 1'b0;
        tick();
        check_reset_values("after_reset");

        for (int n = 0; n < 40; n++) begin
            random_plan();
            run_txn(8'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
